// File: rtl/i2c_slave_regfile.sv
// I2C target serving an internal byte register file: START/STOP decode, 7-bit address match,
// pointer write, burst writes and burst reads from the current pointer. SDA is open-drain via sda_oe.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1101001,
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT      = 4'd9;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ack_phase_q, ack_phase_d;
  logic          rw_q, rw_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];

  logic [7:0]    rx_byte;
  logic [AW-1:0] ptr_inc;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_prev_d = scl_s;
  assign sda_prev_d = sda_s;

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign ptr_inc = ptr_q + AW'(1);

  // NOTE: every *_d gets its hold value first so no path through the case leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    ack_phase_d = ack_phase_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (start_det) begin
      state_d     = S_ADDR;
      bitcnt_d    = 4'd0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = S_IDLE;
      bitcnt_d    = 4'd0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              if (state_q == S_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = S_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = S_WAIT;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = S_PTR_ACK;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_addr_d     = ptr_q;
                wr_data_d     = rx_byte;
                wr_strobe_d   = 1'b1;
                ptr_d         = ptr_inc;
                state_d       = S_WDATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          // First fall after the byte pulls SDA for the ACK slot; the next fall ends it.
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              bitcnt_d    = 4'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d  = S_RDATA;
                sda_oe_d = ~regs_q[ptr_q][7];
                shift_d  = {regs_q[ptr_q][6:0], 1'b0};
                bitcnt_d = 4'd1;
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          // bitcnt counts bits already driven onto the line.
          if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = S_RDATA_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda_s) begin
              state_d  = S_RDATA;
              shift_d  = regs_q[ptr_inc];
              bitcnt_d = 4'd0;
            end else begin
              state_d  = S_WAIT;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        S_WAIT: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bitcnt_q    <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      // NOTE: the register file is cleared by reset on purpose; it is small flop storage, not a RAM macro.
      regs_q      <= '{default: 8'h00};
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-banged I2C master drives directed transactions; expected
// bus bytes/ACKs and register writes are queued at issue and checked by independent monitors.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  typedef struct {
    string      name;
    logic [7:0] val;
  } bus_exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] wr_data, host_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  bus_exp_t   bus_q[$];
  wr_exp_t    wr_q[$];
  logic [7:0] samp_val;
  event       samp_ev;

  assign sda_in = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_addr  (host_addr),
    .host_rdata (host_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic publish(input logic [7:0] v);
    samp_val = v;
    ->samp_ev;
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #40; scl = 1'b1; #80; scl = 1'b0; #40;
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; #40; scl = 1'b1; #40; b = sda_in; #40; scl = 1'b0; #40;
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; #80; scl = 1'b0; #40;
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; #40; scl = 1'b1; #80; m_sda = 1'b0; #80; scl = 1'b0; #40;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #40; scl = 1'b1; #80; m_sda = 1'b1; #80;
  endtask

  // ack=1 expects the target to pull SDA low in the 9th slot.
  task automatic write_byte(input logic [7:0] b, input logic ack, input string nm);
    logic a;
    bus_q.push_back('{name: nm, val: (ack ? 8'h00 : 8'h01)});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_bit(a);
    publish({7'b0, a});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack, input string nm);
    logic [7:0] v;
    logic       bt;
    bus_q.push_back('{name: nm, val: exp});
    for (int i = 7; i >= 0; i--) begin
      get_bit(bt);
      v[i] = bt;
    end
    publish(v);
    send_bit(~mack);
  endtask

  task automatic host_check(input logic [3:0] a, input logic [7:0] exp, input string nm);
    host_addr = a;
    #1;
    check(nm, host_rdata, exp);
  endtask

  initial begin : bus_mon
    bus_exp_t e;
    forever begin
      @(samp_ev);
      if (bus_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL bus_unexpected: got %02h with nothing expected", samp_val);
      end else begin
        e = bus_q.pop_front();
        check(e.name, samp_val, e.val);
      end
    end
  end

  initial begin : wr_mon
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: got addr=%0d data=%02h with nothing expected", wr_addr, wr_data);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", wr_data, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    #23;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 4'd0);
    check("rst_wr_data", wr_data, 8'h00);
    host_check(4'd9, 8'h00, "rst_reg9");
    reset = 1'b1;
    #100;

    // Write two bytes from pointer 3.
    exp_wr(4'd3, 8'hA5);
    exp_wr(4'd4, 8'h5A);
    i2c_start();
    write_byte(8'hD2, 1'b1, "t1_addr_ack");
    check("t1_busy", busy, 1'b1);
    write_byte(8'h03, 1'b1, "t1_ptr_ack");
    write_byte(8'hA5, 1'b1, "t1_d0_ack");
    write_byte(8'h5A, 1'b1, "t1_d1_ack");
    i2c_stop();
    check("t1_busy_after_stop", busy, 1'b0);
    check("t1_last_wr_addr", wr_addr, 4'd4);
    check("t1_last_wr_data", wr_data, 8'h5A);
    host_check(4'd4, 8'h5A, "t1_reg4");
    host_check(4'd3, 8'hA5, "t1_reg3");

    // Seed reg 5 so the post-read pointer is observable.
    exp_wr(4'd5, 8'h3C);
    i2c_start();
    write_byte(8'hD2, 1'b1, "seed_addr_ack");
    write_byte(8'h05, 1'b1, "seed_ptr_ack");
    write_byte(8'h3C, 1'b1, "seed_d_ack");
    i2c_stop();

    // Address mismatch: no ACK, not busy, nothing written.
    i2c_start();
    write_byte(8'hA0, 1'b0, "t2_addr_nack");
    check("t2_busy", busy, 1'b0);
    check("t2_sda_oe", sda_oe, 1'b0);
    write_byte(8'hFF, 1'b0, "t2_data_ignored");
    i2c_stop();
    host_check(4'd3, 8'hA5, "t2_reg3_kept");
    host_check(4'd4, 8'h5A, "t2_reg4_kept");

    // Pointer set, repeated START, burst read with ACK then NACK.
    i2c_start();
    write_byte(8'hD2, 1'b1, "t3_addr_w_ack");
    write_byte(8'h03, 1'b1, "t3_ptr_ack");
    i2c_rstart();
    write_byte(8'hD3, 1'b1, "t3_addr_r_ack");
    read_byte(8'hA5, 1'b1, "t3_rd0");
    read_byte(8'h5A, 1'b0, "t3_rd1");
    check("t3_sda_oe_after_nack", sda_oe, 1'b0);
    check("t3_busy_after_nack", busy, 1'b0);
    i2c_stop();
    i2c_start();
    write_byte(8'hD3, 1'b1, "t3_addr_r2_ack");
    read_byte(8'h3C, 1'b0, "t3_ptr_at5");
    i2c_stop();

    // Pointer wrap at NREGS-1 and pointer byte reduced mod NREGS.
    exp_wr(4'd15, 8'h11);
    exp_wr(4'd0, 8'h22);
    i2c_start();
    write_byte(8'hD2, 1'b1, "t4_addr_ack");
    write_byte(8'h0F, 1'b1, "t4_ptr_ack");
    write_byte(8'h11, 1'b1, "t4_d0_ack");
    write_byte(8'h22, 1'b1, "t4_d1_ack");
    i2c_stop();
    host_check(4'd15, 8'h11, "t4_reg15");
    host_check(4'd0, 8'h22, "t4_reg0");
    exp_wr(4'd3, 8'h77);
    i2c_start();
    write_byte(8'hD2, 1'b1, "t4b_addr_ack");
    write_byte(8'h13, 1'b1, "t4b_ptr_ack");
    write_byte(8'h77, 1'b1, "t4b_d_ack");
    i2c_stop();
    host_check(4'd3, 8'h77, "t4b_reg3");

    // STOP after four address bits.
    i2c_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    check("t6_busy", busy, 1'b0);
    check("t6_sda_oe", sda_oe, 1'b0);

    // Reset while the target drives bit 7 (0) of reg 4 = 0x5A.
    i2c_start();
    write_byte(8'hD3, 1'b1, "t5_addr_ack");
    check("t5_oe_driving", sda_oe, 1'b1);
    check("t5_busy_before", busy, 1'b1);
    host_addr = 4'd4;
    reset = 1'b0;
    #1;
    check("t5_sda_oe_rst", sda_oe, 1'b0);
    check("t5_busy_rst", busy, 1'b0);
    check("t5_reg4_rst", host_rdata, 8'h00);
    host_check(4'd15, 8'h00, "t5_reg15_rst");
    m_sda = 1'b1;
    scl   = 1'b1;
    #50;
    reset = 1'b1;
    #50;
    check("t5_busy_idle", busy, 1'b0);
    exp_wr(4'd7, 8'h99);
    i2c_start();
    write_byte(8'hD2, 1'b1, "t5_post_addr_ack");
    write_byte(8'h07, 1'b1, "t5_post_ptr_ack");
    write_byte(8'h99, 1'b1, "t5_post_d_ack");
    i2c_stop();
    host_check(4'd7, 8'h99, "t5_post_reg7");

    #100;
    check("wr_q_drained", wr_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
